mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester and a
// memory-stage (data) requester. One access is in flight at a time.
//
// Arbitration: data normally beats fetch. A 3-bit streak counter tracks data grants made
// while fetch was waiting. Once the counter reaches STARVE_LIMIT, fetch wins the next
// collision. A busy access that sees no mem_ready_i for TIMEOUT cycles is aborted. The
// abort completes the access with zero read data and sets the sticky err_o flag.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   if_req_i, if_addr_i           fetch read request (held until if_valid_o)
//   if_rdata_o, if_valid_o        fetch read data and one-cycle completion pulse
//   if_stall_o                    fetch stall (request pending, no completion this cycle)
//   dm_req_i, dm_wr_i             data request (held until dm_valid_o), 1 = write
//   dm_addr_i, dm_wdata_i         data address and write data
//   dm_rdata_o, dm_valid_o        data read result and one-cycle completion pulse
//   dm_stall_o                    data stall
//   mem_req_o, mem_wr_o           shared memory port request and write strobe (registered)
//   mem_addr_o, mem_wdata_o       registered command fields, held for the whole access
//   mem_ready_i, mem_rdata_i      memory completion and read data
//   err_o                         sticky timeout flag, cleared only by reset
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // fetch port
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  output logic              if_stall_o,
  // data port
  input  logic              dm_req_i,
  input  logic              dm_wr_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_valid_o,
  output logic              dm_stall_o,
  // shared memory port
  output logic              mem_req_o,
  output logic              mem_wr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  // status
  output logic              err_o
);

  localparam int unsigned WaitW = $clog2(TIMEOUT) + 1;
  localparam logic [2:0]       StarveMax = 3'(STARVE_LIMIT);
  localparam logic [WaitW-1:0] WaitMax   = WaitW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIfBusy,
    StDmBusy
  } state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic              dm_valid_q, dm_valid_d;
  logic [2:0]        streak_q, streak_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              err_q, err_d;

  logic grant_dm;
  logic timed_out;

  // Data wins a collision unless fetch has already lost STARVE_LIMIT times in a row.
  assign grant_dm  = dm_req_i && (!if_req_i || (streak_q != StarveMax));
  assign timed_out = (wait_q == WaitMax);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
      streak_q    <= '0;
      wait_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
      streak_q    <= streak_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    streak_d    = streak_q;
    wait_d      = wait_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        // mem_ready_i is deliberately not looked at here.
        if (grant_dm) begin
          state_d     = StDmBusy;
          mem_req_d   = 1'b1;
          mem_wr_d    = dm_wr_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          wait_d      = '0;
          // grant_dm with fetch waiting implies streak_q < StarveMax, so this saturates.
          if (if_req_i) begin
            streak_d = streak_q + 3'd1;
          end
        end else if (if_req_i) begin
          state_d     = StIfBusy;
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          wait_d      = '0;
          streak_d    = '0;
        end
      end

      StIfBusy, StDmBusy: begin
        if (mem_ready_i || timed_out) begin
          // Ready in the timeout cycle still counts as a normal completion.
          state_d   = StIdle;
          mem_req_d = 1'b0;
          mem_wr_d  = 1'b0;
          if (!mem_ready_i) begin
            err_d = 1'b1;
          end
          if (state_q == StIfBusy) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_ready_i ? mem_rdata_i : '0;
          end else begin
            dm_valid_d = 1'b1;
            if (!mem_ready_i) begin
              dm_rdata_d = '0;
            end else if (!mem_wr_q) begin
              dm_rdata_d = mem_rdata_i;
            end
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end

      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
        mem_wr_d  = 1'b0;
      end
    endcase
  end

  assign mem_req_o   = mem_req_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_valid_o  = if_valid_q;
  assign dm_valid_o  = dm_valid_q;
  assign err_o       = err_q;

  assign if_stall_o = if_req_i && !if_valid_q;
  assign dm_stall_o = dm_req_i && !dm_valid_q;

endmodule
